// File: rtl/delay_counter.sv
// delay_counter: prescaled countdown of delay_value units with IDLE/RUN/DONE control.
module delay_counter #(
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_delay_counter,
  input  logic             enable_delay_counter,
  input  logic             clear,
  input  logic [WIDTH-1:0] delay_value,
  output logic             delay_done,
  output logic             busy,
  output logic             unit_tick,
  output logic [WIDTH-1:0] remaining
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] unit_q, unit_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tick_q, tick_d;
  logic             wrap;
  assign wrap = pre_q == PW'(PRESCALE - 1);
  always_comb begin
    state_d = state_q;
    unit_d  = unit_q;
    pre_d   = pre_q;
    tick_d  = 1'b0;
    if (clear) begin
      state_d = IDLE;
      unit_d  = '0;
      pre_d   = '0;
    end else if (start_delay_counter) begin
      state_d = (delay_value == '0) ? DONE : RUN;
      unit_d  = delay_value;
      pre_d   = '0;
    end else if (state_q == RUN && enable_delay_counter) begin
      // unit_q is at least 1 in RUN, so the decrement never wraps below zero
      pre_d   = wrap ? '0 : pre_q + PW'(1);
      unit_d  = wrap ? unit_q - WIDTH'(1) : unit_q;
      tick_d  = wrap;
      state_d = (wrap && unit_q == WIDTH'(1)) ? DONE : RUN;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      unit_q  <= '0;
      pre_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      unit_q  <= unit_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
    end
  end
  assign delay_done = state_q == DONE;
  assign busy       = state_q == RUN;
  assign unit_tick  = tick_q;
  assign remaining  = unit_q;
endmodule

// File: tb/tb_delay_counter.sv
// tb_delay_counter: PRESCALE=4 and PRESCALE=1 instances against an enabled-cycle budget model.
module tb_delay_counter;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, en = 1'b0, clr = 1'b0;
  logic [7:0] dv = '0;
  logic done4, busy4, tick4, done1, busy1, tick1;
  logic [7:0] rem4, rem1;
  int n_cmp = 0, n_err = 0;
  int ticks_at[$];
  int left[2] = '{0, 0};
  bit act[2] = '{0, 0};
  bit tk[2] = '{0, 0};
  always #5 clk = ~clk;
  delay_counter #(.PRESCALE(4), .WIDTH(8)) dut4 (
    .clk(clk), .reset(reset), .start_delay_counter(start), .enable_delay_counter(en),
    .clear(clr), .delay_value(dv), .delay_done(done4), .busy(busy4), .unit_tick(tick4),
    .remaining(rem4));
  delay_counter #(.PRESCALE(1), .WIDTH(8)) dut1 (
    .clk(clk), .reset(reset), .start_delay_counter(start), .enable_delay_counter(en),
    .clear(clr), .delay_value(dv), .delay_done(done1), .busy(busy1), .unit_tick(tick1),
    .remaining(rem1));
  // Model: a delay is a budget of delay_value*PRESCALE enabled cycles; units left = ceil(budget/PRESCALE).
  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset || clr) begin
        act[k] <= 0; left[k] <= 0; tk[k] <= 0;
      end else if (start) begin
        act[k] <= 1; left[k] <= int'(dv) * (k ? 1 : 4); tk[k] <= 0;
      end else if (act[k] && left[k] > 0 && en) begin
        left[k] <= left[k] - 1; tk[k] <= ((left[k] - 1) % (k ? 1 : 4)) == 0;
      end else tk[k] <= 0;
    end
  end
  always @(negedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        int p;
        logic gb, gd, gt, eb, ed, et;
        logic [7:0] gr, er;
        p = k ? 1 : 4;
        gb = k ? busy1 : busy4; gd = k ? done1 : done4;
        gt = k ? tick1 : tick4; gr = k ? rem1 : rem4;
        eb = act[k] && left[k] > 0; ed = act[k] && left[k] == 0; et = tk[k];
        er = act[k] ? 8'((left[k] + p - 1) / p) : 8'd0;
        n_cmp += 4;
        if (gb !== eb) begin n_err++; $display("FAIL busy P=%0d t=%0t got %b exp %b", p, $time, gb, eb); end
        if (gd !== ed) begin n_err++; $display("FAIL delay_done P=%0d t=%0t got %b exp %b", p, $time, gd, ed); end
        if (gt !== et) begin n_err++; $display("FAIL unit_tick P=%0d t=%0t got %b exp %b", p, $time, gt, et); end
        if (gr !== er) begin n_err++; $display("FAIL remaining P=%0d t=%0t got %0d exp %0d", p, $time, gr, er); end
      end
    end
  end
  task automatic kick(input logic [7:0] v);
    @(negedge clk); dv = v; start = 1'b1; en = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask
  // Cycle c is the one following edge c-1 after the start edge; en for that cycle is driven at its beginning.
  task automatic measure(input bit sel, input int n, input int p_at, input int p_len,
                         output int done_at, output int nticks, output int busy_seen);
    done_at = 0; nticks = 0; busy_seen = 0; ticks_at.delete();
    for (int c = 1; c <= n; c++) begin
      en = !(c >= p_at && c < p_at + p_len);
      if ((sel ? done1 : done4) && done_at == 0) done_at = c;
      if (sel ? tick1 : tick4) begin nticks++; ticks_at.push_back(c); end
      if (sel ? busy1 : busy4) busy_seen++;
      @(posedge clk); #1;
    end
  endtask
  task automatic test_reset();
    reset = 1'b1; start = 1'b1; dv = 8'd3; en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({done4, busy4, tick4, rem4, done1, busy1, tick1, rem1} !== '0) begin
      n_err++; $display("FAIL reset_outputs got %b exp 0", {done4, busy4, tick4, rem4, done1, busy1, tick1, rem1});
    end
    @(negedge clk); start = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({done4, busy4, tick4, rem4} !== '0) begin
      n_err++; $display("FAIL reset_enable_idle got %b exp 0", {done4, busy4, tick4, rem4});
    end
  endtask
  task automatic test_basic();
    int d, t, b;
    kick(8'd3);
    n_cmp++;
    if (busy4 !== 1'b1 || rem4 !== 8'd3) begin n_err++; $display("FAIL basic_cycle1 got busy=%b rem=%0d exp busy=1 rem=3", busy4, rem4); end
    measure(0, 16, 0, 0, d, t, b);
    n_cmp++;
    if (d !== 13) begin n_err++; $display("FAIL basic_done_cycle got %0d exp 13", d); end
    n_cmp++;
    if (t !== 3 || ticks_at[0] != 5 || ticks_at[1] != 9 || ticks_at[2] != 13) begin
      n_err++; $display("FAIL basic_tick_cycles got count %0d first %0d exp 3 at 5,9,13", t, t > 0 ? ticks_at[0] : 0);
    end
  endtask
  task automatic test_zero();
    int d, t, b;
    kick(8'd0);
    measure(0, 8, 0, 0, d, t, b);
    n_cmp++;
    if (d !== 1 || t !== 0 || b !== 0) begin n_err++; $display("FAIL zero_delay got done@%0d ticks %0d busy %0d exp 1/0/0", d, t, b); end
  endtask
  task automatic test_pause();
    int d, t, b;
    kick(8'd2);
    measure(0, 20, 4, 5, d, t, b);
    n_cmp++;
    if (d !== 14) begin n_err++; $display("FAIL pause_done_cycle got %0d exp 14", d); end
  endtask
  task automatic test_restart();
    int d, t, b;
    kick(8'd5);
    measure(0, 7, 0, 0, d, t, b);
    kick(8'd1);
    measure(0, 8, 0, 0, d, t, b);
    n_cmp++;
    if (d !== 5) begin n_err++; $display("FAIL restart_done_cycle got %0d exp 5", d); end
    @(negedge clk); clr = 1'b1; start = 1'b1; dv = 8'd9;
    @(posedge clk); #1; clr = 1'b0; start = 1'b0;
    n_cmp++;
    if ({done4, busy4, rem4} !== '0) begin n_err++; $display("FAIL clear_beats_start got %b exp 0", {done4, busy4, rem4}); end
  endtask
  task automatic test_async_reset();
    int d, t, b;
    kick(8'd3);
    measure(0, 6, 0, 0, d, t, b);
    #3 reset = 1'b1;
    #1;
    n_cmp++;
    if ({done4, busy4, tick4, rem4, done1, busy1, tick1, rem1} !== '0) begin
      n_err++; $display("FAIL async_reset got %b exp 0", {done4, busy4, tick4, rem4, done1, busy1, tick1, rem1});
    end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    measure(0, 10, 0, 0, d, t, b);
    n_cmp++;
    if (d !== 0 || b !== 0) begin n_err++; $display("FAIL async_stays_idle got done@%0d busy %0d exp 0/0", d, b); end
  endtask
  task automatic test_max();
    int d, t, b;
    kick(8'd255);
    measure(1, 300, 0, 0, d, t, b);
    n_cmp++;
    if (d !== 256) begin n_err++; $display("FAIL max_done_cycle got %0d exp 256", d); end
    n_cmp++;
    if (t !== 255) begin n_err++; $display("FAIL max_tick_count got %0d exp 255", t); end
  endtask
  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      clr = $urandom_range(0, 39) == 0;
      start = $urandom_range(0, 11) == 0;
      en = $urandom_range(0, 3) != 0;
      dv = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
    end
    @(negedge clk); clr = 1'b1; start = 1'b0;
    @(negedge clk); clr = 1'b0;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_pause();
    test_restart();
    test_async_reset();
    test_max();
    test_random();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/delay_counter.md
DELAY_COUNTER -- requirements
Module: delay_counter

Interface
REQ-001 SHALL have parameter PRESCALE, default 50000, meaning enabled clock cycles per delay unit (1 ms at 50 MHz); legal range 1..2^20.
REQ-002 SHALL have parameter WIDTH, default 8, meaning width of the delay value (matches RF[3]).
REQ-003 SHALL have port clk  input  1  sole clock; all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start_delay_counter  input  1  load delay_value and arm the counter (from control FSM).
REQ-006 SHALL have port enable_delay_counter  input  1  advance the counter this cycle (from control FSM).
REQ-007 SHALL have port clear  input  1  synchronous abort to IDLE.
REQ-008 SHALL have port delay_value  input  WIDTH  delay in units (RF[3] read port).
REQ-009 SHALL have port delay_done  output  1  high while in DONE; consumed combinationally by control FSM.
REQ-010 SHALL have port busy  output  1  high while in RUN.
REQ-011 SHALL have port unit_tick  output  1  one-cycle pulse on each unit decrement.
REQ-012 SHALL have port remaining  output  WIDTH  current unit count.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE; all outputs decoded from registered state/counters only (no combinational input-to-output path).
REQ-014 SHALL hold internal unit counter (WIDTH bits) and prescale counter (max(1,clog2(PRESCALE)) bits).
REQ-015 Priority per cycle SHALL be: clear > start_delay_counter > enable_delay_counter.
REQ-016 clear in any state SHALL go to IDLE, zero both counters, same edge.
REQ-017 start in any state (clear low) SHALL load unit counter = delay_value, zero prescaler, and enter RUN, or DONE directly if delay_value = 0; restart mid-RUN or in DONE discards the old count.
REQ-018 In RUN with enable high: prescaler increments; when prescaler = PRESCALE-1 it wraps to 0, unit counter decrements, unit_tick pulses next cycle.
REQ-019 In RUN when the decrement takes unit counter from 1 to 0, next state SHALL be DONE.
REQ-020 In RUN with enable low: both counters SHALL freeze (pause, no loss of progress).
REQ-021 delay_done SHALL first assert exactly N*PRESCALE enabled RUN cycles after the start edge (N = delay_value), i.e. N*PRESCALE+1 cycles after start when enable is continuous.
REQ-022 DONE SHALL persist, ignoring enable, until start or clear; IDLE ignores enable.
REQ-023 unit counter SHALL never underflow; remaining = 0 in IDLE and DONE.
REQ-024 PRESCALE = 1 SHALL decrement on every enabled RUN cycle.
REQ-025 Counting SHALL be unsigned; delay_value = 2^WIDTH-1 SHALL yield the full (2^WIDTH-1)*PRESCALE delay.

Reset
REQ-026 reset high SHALL asynchronously force IDLE, counters 0, delay_done 0, busy 0, unit_tick 0, remaining 0.
REQ-027 Reset assertion mid-RUN SHALL abandon the count; after deassertion the block waits for start.
REQ-028 No output SHALL glitch high during reset deassertion.

Verification (PRESCALE=4, WIDTH=8)
REQ-029 reset, start with delay_value=3, enable continuous -> busy 1 from next cycle, unit_tick at cycles 5,9,13 after start, delay_done rises cycle 13, remaining 3->2->1->0.
REQ-030 start with delay_value=0 -> delay_done=1 the cycle after start, busy never 1, no unit_tick.
REQ-031 delay_value=2, enable low for 5 cycles mid-count -> delay_done delayed by exactly 5 cycles (rises cycle 14).
REQ-032 delay_value=5, restart with delay_value=1 after 7 enabled cycles -> delay_done 5 cycles after restart; clear and start together -> IDLE.
REQ-033 async reset asserted mid-RUN between clock edges -> all outputs 0 immediately; enable alone afterward -> stays IDLE.
REQ-034 delay_value=255 with PRESCALE=1 -> delay_done exactly 256 cycles after start, 255 unit_tick pulses.
